// File: rtl/wb_cmd_master.sv
// wb_cmd_master: byte-stream command decoder driving single Wishbone read/write accesses with timeout
module wb_cmd_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_cmd_dat,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    output logic [7:0]  o_rsp_dat,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [15:0] o_wb_dat,
    input  logic [15:0] i_wb_dat,
    input  logic        i_wb_ack
);
    typedef enum logic [3:0] {
        IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, BUS, RSP_STAT, RSP_DH, RSP_DL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  status_q, status_d;
    logic        we_q, we_d;
    logic        cmd_fire, rsp_fire;

    assign o_cmd_ready = state_q inside {IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L};
    assign o_rsp_valid = state_q inside {RSP_STAT, RSP_DH, RSP_DL};
    assign o_rsp_dat   = state_q == RSP_STAT ? status_q :
                         state_q == RSP_DH   ? rdat_q[15:8] :
                         state_q == RSP_DL   ? rdat_q[7:0] : 8'h00;
    assign o_wb_cyc    = state_q == BUS;
    assign o_wb_stb    = o_wb_cyc;
    assign o_wb_we     = o_wb_cyc & we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_dat    = wdat_q;
    assign cmd_fire    = i_cmd_valid & o_cmd_ready;
    assign rsp_fire    = o_rsp_valid & i_rsp_ready;

    // Next-state logic: frame parsing, bus access with timeout, response sequencing
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        we_d     = we_q;
        case (state_q)
            IDLE: if (cmd_fire) begin
                we_d   = i_cmd_dat == 8'h01;
                wdat_d = 16'h0000;
                cnt_d  = 8'h00;
                if (i_cmd_dat == 8'h01 || i_cmd_dat == 8'h02) begin
                    state_d = ADDR_H;
                end else if (i_cmd_dat == 8'h03) begin
                    addr_d  = addr_q + 16'd1;
                    state_d = BUS;
                end else begin
                    status_d = 8'hFF;
                    state_d  = RSP_STAT;
                end
            end
            ADDR_H: if (cmd_fire) begin
                addr_d[15:8] = i_cmd_dat;
                state_d      = ADDR_L;
            end
            ADDR_L: if (cmd_fire) begin
                addr_d[7:0] = i_cmd_dat;
                state_d     = we_q ? DATA_H : BUS;
            end
            DATA_H: if (cmd_fire) begin
                wdat_d[15:8] = i_cmd_dat;
                state_d      = DATA_L;
            end
            DATA_L: if (cmd_fire) begin
                wdat_d[7:0] = i_cmd_dat;
                state_d     = BUS;
            end
            BUS: if (i_wb_ack) begin
                rdat_d   = we_q ? rdat_q : i_wb_dat;
                status_d = 8'h00;
                state_d  = RSP_STAT;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                status_d = 8'hEE;
                state_d  = RSP_STAT;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RSP_STAT: if (rsp_fire) state_d = (status_q == 8'h00 && !we_q) ? RSP_DH : IDLE;
            RSP_DH:   if (rsp_fire) state_d = RSP_DL;
            RSP_DL:   if (rsp_fire) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            addr_q   <= 16'h0000;
            wdat_q   <= 16'h0000;
            rdat_q   <= 16'h0000;
            cnt_q    <= 8'h00;
            status_q <= 8'h00;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            we_q     <= we_d;
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;
    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_cmd_dat = 8'h00;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [7:0]  o_rsp_dat;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [15:0] o_wb_addr;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [15:0] o_wb_dat;
    logic [15:0] i_wb_dat = 16'h0000;
    logic        i_wb_ack = 1'b0;
    int checks = 0;
    int errors = 0;

    wb_cmd_master #(.TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cmd_dat(i_cmd_dat), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .o_rsp_dat(o_rsp_dat), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
    );

    // Free-running clock
    always #5 i_clk = ~i_clk;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!o_cmd_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: o_cmd_ready=%b required 1", o_cmd_ready);
        end
        i_cmd_dat   = b;
        i_cmd_valid = 1'b1;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input string nm);
        int n = 0;
        while (!o_rsp_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_dat !== exp) begin
            errors++;
            $display("FAIL %s: valid=%b dat=%h required valid=1 dat=%h", nm, o_rsp_valid, o_rsp_dat, exp);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if ({o_rsp_valid, o_cmd_ready, o_wb_cyc} !== 3'b010) begin
            errors++;
            $display("FAIL %s: rsp_valid=%b cmd_ready=%b cyc=%b required 0 1 0", nm, o_rsp_valid, o_cmd_ready, o_wb_cyc);
        end
    endtask

    task automatic read_ack(input logic [15:0] exp_addr, input logic [15:0] rd, input string nm);
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat} !== {3'b110, exp_addr, 16'h0000}) begin
            errors++;
            $display("FAIL %s_bus: cyc=%b stb=%b we=%b addr=%h dat=%h required 1 1 0 %h 0000",
                     nm, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, exp_addr);
        end
        i_wb_dat = rd;
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        i_wb_dat = 16'h0000;
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_rsp_valid} !== 3'b001) begin
            errors++;
            $display("FAIL %s_end: cyc=%b stb=%b rsp_valid=%b required 0 0 1", nm, o_wb_cyc, o_wb_stb, o_rsp_valid);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_cmd_ready, o_rsp_valid, o_rsp_dat, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat}
            !== {2'b10, 8'h00, 3'b000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b rdat=%h cyc=%b stb=%b we=%b addr=%h wdat=%h required 1 0 00 0 0 0 0000 0000",
                     o_cmd_ready, o_rsp_valid, o_rsp_dat, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat);
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check_idle("reset_release");
    endtask

    task automatic test_write();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h05); send_byte(8'hAB); send_byte(8'hCD);
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat} !== {3'b111, 16'h1005, 16'hABCD}) begin
            errors++;
            $display("FAIL wr_bus1: cyc=%b stb=%b we=%b addr=%h dat=%h required 1 1 1 1005 abcd",
                     o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat);
        end
        @(negedge i_clk);
        checks++;
        if ({o_wb_cyc, o_cmd_ready, o_wb_we, o_wb_addr, o_wb_dat} !== {3'b101, 16'h1005, 16'hABCD}) begin
            errors++;
            $display("FAIL wr_bus2: cyc=%b ready=%b we=%b addr=%h dat=%h required 1 0 1 1005 abcd",
                     o_wb_cyc, o_cmd_ready, o_wb_we, o_wb_addr, o_wb_dat);
        end
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin
            errors++;
            $display("FAIL wr_drop: cyc=%b stb=%b we=%b required 0 0 0", o_wb_cyc, o_wb_stb, o_wb_we);
        end
        recv_byte(8'h00, "wr_status");
        check_idle("wr_idle");
    endtask

    task automatic test_read();
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h05);
        read_ack(16'h1005, 16'h1234, "rd");
        recv_byte(8'h00, "rd_status");
        recv_byte(8'h12, "rd_hi");
        recv_byte(8'h34, "rd_lo");
        check_idle("rd_idle");
        send_byte(8'h03);
        read_ack(16'h1006, 16'h5678, "rdn");
        recv_byte(8'h00, "rdn_status");
        recv_byte(8'h56, "rdn_hi");
        recv_byte(8'h78, "rdn_lo");
    endtask

    task automatic test_wrap();
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
        read_ack(16'hFFFF, 16'hA55A, "wrap_first");
        recv_byte(8'h00, "wrap_first_status");
        recv_byte(8'hA5, "wrap_first_hi");
        recv_byte(8'h5A, "wrap_first_lo");
        send_byte(8'h03);
        read_ack(16'h0000, 16'h0F0F, "wrap_next");
        recv_byte(8'h00, "wrap_next_status");
        recv_byte(8'h0F, "wrap_next_hi");
        recv_byte(8'h0F, "wrap_next_lo");
    endtask

    task automatic test_timeout();
        int n = 0;
        send_byte(8'h02); send_byte(8'h20); send_byte(8'h00);
        while (o_wb_cyc && n < 100) begin
            n++;
            @(negedge i_clk);
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_len: cyc high %0d cycles required 16", n);
        end
        recv_byte(8'hEE, "timeout_status");
        check_idle("timeout_only_status");
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        @(negedge i_clk);
        check_idle("ack_outside_bus");
        send_byte(8'h03);
        repeat (15) @(negedge i_clk);
        checks++;
        if ({o_wb_cyc, o_wb_addr} !== {1'b1, 16'h2001}) begin
            errors++;
            $display("FAIL ack_wins_bus: cyc=%b addr=%h required 1 2001", o_wb_cyc, o_wb_addr);
        end
        i_wb_dat = 16'hBEEF;
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        i_wb_dat = 16'h0000;
        recv_byte(8'h00, "ack_wins_status");
        recv_byte(8'hBE, "ack_wins_hi");
        recv_byte(8'hEF, "ack_wins_lo");
    endtask

    task automatic test_bad_op();
        int bad = 0;
        send_byte(8'h7F);
        for (int i = 0; i < 5; i++) begin
            if (o_rsp_valid !== 1'b1 || o_rsp_dat !== 8'hFF || o_wb_cyc !== 1'b0) bad++;
            @(negedge i_clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bad_op_hold: %0d of 5 stalled cycles wrong, required valid=1 dat=ff cyc=0", bad);
        end
        recv_byte(8'hFF, "bad_op_status");
        check_idle("bad_op_idle");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h02); send_byte(8'h30); send_byte(8'h00);
        checks++;
        if (o_wb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_cyc: cyc=%b required 1", o_wb_cyc);
        end
        i_reset_n = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        checks++;
        if ({o_wb_cyc, o_rsp_valid, o_wb_addr} !== {2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL rstmid_drop: cyc=%b valid=%b addr=%h required 0 0 0000", o_wb_cyc, o_rsp_valid, o_wb_addr);
        end
        repeat (3) @(negedge i_clk);
        check_idle("rstmid_no_rsp");
        send_byte(8'h01); send_byte(8'h12);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        send_byte(8'h02); send_byte(8'h40); send_byte(8'h00);
        read_ack(16'h4000, 16'hC3C3, "rstmid_next");
        recv_byte(8'h00, "rstmid_next_status");
        recv_byte(8'hC3, "rstmid_next_hi");
        recv_byte(8'hC3, "rstmid_next_lo");
        check_idle("rstmid_final");
    endtask

    // Test sequence
    initial begin
        @(negedge i_clk);
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_timeout();
        test_bad_op();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
